// File: rtl/dmac_ahb_burst_master.sv
// dmac_ahb_burst_master
// AHB-Lite burst master for the DMA controller. Takes one command at a time
// (direction, start address, beat count) and issues pipelined incrementing
// transfers. Write beats stream in on wr_*, read beats stream out on rd_*.
// Adds BUSY insertion on write-data underrun, 1KB-boundary splitting and
// abort on an ERROR response.
//
// Build option: define DMAC_BURST_EN to issue INCR4/8/16/INCR bursts with SEQ
// beats and BUSY on underrun. Without it, every beat is a NONSEQ SINGLE and an
// underrun shows IDLE.
//
// The write source follows valid/ready rules. Once wr_valid_i is high, it
// stays high until wr_ready_o takes the beat. A driven NONSEQ/SEQ therefore
// never changes type during slave wait states.

`timescale 1ns/1ps

module dmac_ahb_burst_master #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [AW-1:0]    cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wr_valid_i,
    input  logic [DW-1:0]    wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    output logic [DW-1:0]    rd_data_o,
    output logic             done_o,
    output logic             err_o,
    output logic             hsel_o,
    output logic [1:0]       htrans_o,
    output logic [2:0]       hsize_o,
    output logic [2:0]       hburst_o,
    output logic             hwrite_o,
    output logic [AW-1:0]    haddr_o,
    output logic [DW-1:0]    hwdata_o,
    input  logic             hreadyin_i,
    input  logic             hresp_i,
    input  logic [DW-1:0]    hrdata_i
);

    localparam int            BYTES      = DW / 8;
    localparam logic [2:0]    SIZE       = (DW == 64) ? 3'd3 : 3'd2;
    localparam logic [AW-1:0] ADDR_INC   = AW'(BYTES);

    localparam logic [1:0]    HT_IDLE    = 2'b00;
    localparam logic [1:0]    HT_BUSY    = 2'b01;
    localparam logic [1:0]    HT_NONSEQ  = 2'b10;
    localparam logic [1:0]    HT_SEQ     = 2'b11;

    localparam logic [2:0]    HB_SINGLE  = 3'b000;
    localparam logic [2:0]    HB_INCR    = 3'b001;
    localparam logic [2:0]    HB_INCR4   = 3'b011;
    localparam logic [2:0]    HB_INCR8   = 3'b101;
    localparam logic [2:0]    HB_INCR16  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      haddr_q, haddr_d;
    logic [2:0]         hburst_q, hburst_d;
    logic               hwrite_q, hwrite_d;
    logic [DW-1:0]      hwdata_q, hwdata_d;
    logic [LEN_W-1:0]   beatCnt_q, beatCnt_d;
    logic               segStart_q, segStart_d;
    logic               dataPhase_q, dataPhase_d;

    logic [1:0]         htransC;
    logic               addrAccept;
    logic               errDetect;
    logic [AW-1:0]      nextAddr;
    logic [2:0]         cmdBurst;

`ifdef DMAC_BURST_EN
    logic [31:0]        beatsW;
    logic [31:0]        endOff;
`endif

    // Transfer type for the current address phase; writes only present a beat when data is on hand
    always_comb begin
        htransC = HT_IDLE;
        unique case (state_q)
            S_ADDR: begin
                if (!hwrite_q || wr_valid_i) begin
                    htransC = HT_NONSEQ;
                end
            end
            S_BURST: begin
                if (!hwrite_q || wr_valid_i) begin
                    htransC = segStart_q ? HT_NONSEQ : HT_SEQ;
                end else begin
`ifdef DMAC_BURST_EN
                    htransC = HT_BUSY;
`else
                    htransC = HT_IDLE;
`endif
                end
            end
            default: htransC = HT_IDLE;
        endcase
    end

    assign addrAccept = ((htransC == HT_NONSEQ) || (htransC == HT_SEQ)) && hreadyin_i;
    assign errDetect  = dataPhase_q && hresp_i && !hreadyin_i;
    assign nextAddr   = haddr_q + ADDR_INC;

    // Burst encoding chosen once per command from its length and whether it crosses a 1KB line
    always_comb begin
`ifdef DMAC_BURST_EN
        beatsW = 32'(cmd_len_i) + 32'd1;
        endOff = 32'(cmd_addr_i[9:0]) + beatsW * 32'(BYTES);
        if (beatsW == 32'd1) begin
            cmdBurst = HB_SINGLE;
        end else if (endOff > 32'd1024) begin
            cmdBurst = HB_INCR;
        end else begin
            unique case (beatsW)
                32'd4:   cmdBurst = HB_INCR4;
                32'd8:   cmdBurst = HB_INCR8;
                32'd16:  cmdBurst = HB_INCR16;
                default: cmdBurst = HB_INCR;
            endcase
        end
`else
        cmdBurst = HB_SINGLE;
`endif
    end

    // Next-state logic: command latch, beat stepping, completion and error abort
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hburst_d    = hburst_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        beatCnt_d   = beatCnt_q;
        segStart_d  = segStart_q;

        if (errDetect) begin
            dataPhase_d = 1'b0;
        end else if (addrAccept) begin
            dataPhase_d = 1'b1;
        end else if (hreadyin_i) begin
            dataPhase_d = 1'b0;
        end else begin
            dataPhase_d = dataPhase_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d    = S_ADDR;
                    hwrite_d   = cmd_write_i;
                    haddr_d    = cmd_addr_i;
                    hburst_d   = cmdBurst;
                    beatCnt_d  = cmd_len_i;
                    segStart_d = 1'b1;
                end
            end
            S_ADDR, S_BURST: begin
                if (errDetect) begin
                    state_d = S_ERR;
                end else if (addrAccept) begin
                    if (hwrite_q) begin
                        hwdata_d = wr_data_i;
                    end
                    if (beatCnt_q == '0) begin
                        state_d = S_LAST;
                    end else begin
                        state_d   = S_BURST;
                        beatCnt_d = beatCnt_q - LEN_W'(1);
                        haddr_d   = nextAddr;
`ifdef DMAC_BURST_EN
                        segStart_d = (nextAddr[9:0] == 10'd0);
`else
                        segStart_d = 1'b1;
`endif
                    end
                end
            end
            S_LAST: begin
                if (errDetect) begin
                    state_d = S_ERR;
                end else if (hreadyin_i) begin
                    state_d  = S_IDLE;
                    haddr_d  = '0;
                    hburst_d = HB_SINGLE;
                    hwrite_d = 1'b0;
                end
            end
            S_ERR: begin
                if (hreadyin_i) begin
                    state_d  = S_IDLE;
                    haddr_d  = '0;
                    hburst_d = HB_SINGLE;
                    hwrite_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and bus-side registers; reset abandons any command in flight without a done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            hburst_q    <= HB_SINGLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            beatCnt_q   <= '0;
            segStart_q  <= 1'b0;
            dataPhase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hburst_q    <= hburst_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            beatCnt_q   <= beatCnt_d;
            segStart_q  <= segStart_d;
            dataPhase_q <= dataPhase_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = hwrite_q && addrAccept;
    assign rd_valid_o  = dataPhase_q && !hwrite_q && hreadyin_i && !hresp_i;
    assign rd_data_o   = rd_valid_o ? hrdata_i : '0;
    assign done_o      = hreadyin_i && ((state_q == S_LAST) || (state_q == S_ERR));
    assign err_o       = hreadyin_i && (state_q == S_ERR);
    assign hsel_o      = (htransC != HT_IDLE);
    assign htrans_o    = htransC;
    assign hsize_o     = (state_q != S_IDLE) ? SIZE : 3'd0;
    assign hburst_o    = hburst_q;
    assign hwrite_o    = hwrite_q;
    assign haddr_o     = haddr_q;
    assign hwdata_o    = hwdata_q;

endmodule

// File: tb/tb_dmac_ahb_burst_master.sv
// tb_dmac_ahb_burst_master
// Directed bench for dmac_ahb_burst_master. Expectations follow the
// DMAC_BURST_EN setting of the build.

`timescale 1ns/1ps

module tb_dmac_ahb_burst_master;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
`ifdef DMAC_BURST_EN
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic       BE     = 1'b1;
`else
    localparam logic [1:0] T_SEQ  = 2'b10;
    localparam logic [1:0] T_BUSY = 2'b00;
    localparam logic       BE     = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [3:0]  cmdLen;
    logic        wrValid;
    logic [31:0] wrData;
    logic        wrReady;
    logic        rdValid;
    logic [31:0] rdData;
    logic        done;
    logic        err;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hresp;
    logic [31:0] hrdata;

    int total = 0;
    int bad   = 0;
    int rdCount = 0;
    int wrCount = 0;

    dmac_ahb_burst_master #(.DW(32), .AW(32), .LEN_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_write_i (cmdWrite),
        .cmd_addr_i  (cmdAddr),
        .cmd_len_i   (cmdLen),
        .wr_valid_i  (wrValid),
        .wr_data_i   (wrData),
        .wr_ready_o  (wrReady),
        .rd_valid_o  (rdValid),
        .rd_data_o   (rdData),
        .done_o      (done),
        .err_o       (err),
        .hsel_o      (hsel),
        .htrans_o    (htrans),
        .hsize_o     (hsize),
        .hburst_o    (hburst),
        .hwrite_o    (hwrite),
        .haddr_o     (haddr),
        .hwdata_o    (hwdata),
        .hreadyin_i  (hreadyin),
        .hresp_i     (hresp),
        .hrdata_i    (hrdata)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Burst code expected for a given burst-mode encoding
    function automatic logic [2:0] hb(input logic [2:0] code);
        return BE ? code : 3'b000;
    endfunction

    // Drive one cycle of inputs just after the rising edge, then settle before sampling
    task automatic applyStimulus(input logic cv, input logic cw, input logic [31:0] ca,
                                 input logic [3:0] cl, input logic wv, input logic [31:0] wd,
                                 input logic hr, input logic hrs, input logic [31:0] hrd);
        @(posedge clk);
        #1;
        cmdValid = cv;
        cmdWrite = cw;
        cmdAddr  = ca;
        cmdLen   = cl;
        wrValid  = wv;
        wrData   = wd;
        hreadyin = hr;
        hresp    = hrs;
        hrdata   = hrd;
        #3;
        if (rdValid) rdCount++;
        if (wrReady) wrCount++;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence following the test plan
    initial begin
        rstN = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
        wrValid = 1'b0; wrData = '0; hreadyin = 1'b1; hresp = 1'b0; hrdata = '0;

        #3;
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_htrans", htrans, T_IDLE);
        checkOutput("rst_hburst", hburst, 3'b000);
        checkOutput("rst_haddr", haddr, 0);
        checkOutput("rst_hsel", hsel, 0);
        checkOutput("rst_hsize", hsize, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_wr_ready", wrReady, 0);
        checkOutput("rst_rd_valid", rdValid, 0);
        #10 rstN = 1'b1;

        $display("[TB] write burst 0x100 x4");
        wrCount = 0;
        applyStimulus(1, 1, 32'h100, 4'd3, 1, 32'hA0, 1, 0, 0);
        checkOutput("w1_c0_ready", cmdReady, 1);
        checkOutput("w1_c0_htrans", htrans, T_IDLE);
        applyStimulus(0, 0, 0, 0, 1, 32'hA0, 1, 0, 0);
        checkOutput("w1_c1_htrans", htrans, T_NSEQ);
        checkOutput("w1_c1_haddr", haddr, 32'h100);
        checkOutput("w1_c1_hburst", hburst, hb(3'b011));
        checkOutput("w1_c1_hwrite", hwrite, 1);
        checkOutput("w1_c1_wr_ready", wrReady, 1);
        checkOutput("w1_c1_hsel", hsel, 1);
        checkOutput("w1_c1_hsize", hsize, 3'd2);
        checkOutput("w1_c1_cmd_ready", cmdReady, 0);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'hA0 + 32'(k), 1, 0, 0);
            checkOutput("w1_seq_htrans", htrans, T_SEQ);
            checkOutput("w1_seq_haddr", haddr, 32'h100 + 32'(4 * k));
            checkOutput("w1_seq_hwdata", hwdata, 32'hA0 + 32'(k - 1));
            checkOutput("w1_seq_wr_ready", wrReady, 1);
        end
        applyStimulus(1, 0, 32'h700, 4'd0, 0, 0, 1, 0, 0);
        checkOutput("w1_last_htrans", htrans, T_IDLE);
        checkOutput("w1_last_hwdata", hwdata, 32'hA3);
        checkOutput("w1_last_done", done, 1);
        checkOutput("w1_last_err", err, 0);
        checkOutput("w1_last_cmd_ready", cmdReady, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("w1_idle_cmd_ready", cmdReady, 1);
        checkOutput("w1_idle_htrans", htrans, T_IDLE);
        checkOutput("w1_idle_done", done, 0);
        checkOutput("w1_wr_count", wrCount, 4);

        $display("[TB] read burst 0x2000 x8 with stall");
        rdCount = 0;
        applyStimulus(1, 0, 32'h2000, 4'd7, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r2_c1_htrans", htrans, T_NSEQ);
        checkOutput("r2_c1_haddr", haddr, 32'h2000);
        checkOutput("r2_c1_hburst", hburst, hb(3'b101));
        checkOutput("r2_c1_rd_valid", rdValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hD0);
        checkOutput("r2_c2_haddr", haddr, 32'h2004);
        checkOutput("r2_c2_rd_data", rdData, 32'hD0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hD1);
        checkOutput("r2_c3_rd_data", rdData, 32'hD1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD);
        checkOutput("r2_stall1_haddr", haddr, 32'h200C);
        checkOutput("r2_stall1_htrans", htrans, T_SEQ);
        checkOutput("r2_stall1_rd_valid", rdValid, 0);
        checkOutput("r2_stall1_rd_data", rdData, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD);
        checkOutput("r2_stall2_haddr", haddr, 32'h200C);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hD2);
        checkOutput("r2_resume_haddr", haddr, 32'h200C);
        checkOutput("r2_resume_rd_data", rdData, 32'hD2);
        for (int k = 3; k < 7; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hD0 + 32'(k));
            checkOutput("r2_seq_haddr", haddr, 32'h2000 + 32'(4 * (k + 1)));
            checkOutput("r2_seq_rd_data", rdData, 32'hD0 + 32'(k));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hD7);
        checkOutput("r2_last_htrans", htrans, T_IDLE);
        checkOutput("r2_last_rd_data", rdData, 32'hD7);
        checkOutput("r2_last_done", done, 1);
        checkOutput("r2_last_err", err, 0);
        checkOutput("r2_rd_count", rdCount, 8);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("[TB] write underrun 0x40 x4");
        wrCount = 0;
        applyStimulus(1, 1, 32'h40, 4'd3, 1, 32'hB0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hB0, 1, 0, 0);
        checkOutput("w3_c1_htrans", htrans, T_NSEQ);
        checkOutput("w3_c1_haddr", haddr, 32'h40);
        applyStimulus(0, 0, 0, 0, 1, 32'hB1, 1, 0, 0);
        checkOutput("w3_c2_htrans", htrans, T_SEQ);
        checkOutput("w3_c2_hwdata", hwdata, 32'hB0);
        applyStimulus(0, 0, 0, 0, 0, 32'hFF, 1, 0, 0);
        checkOutput("w3_busy1_htrans", htrans, T_BUSY);
        checkOutput("w3_busy1_haddr", haddr, 32'h48);
        checkOutput("w3_busy1_wr_ready", wrReady, 0);
        checkOutput("w3_busy1_hsel", hsel, BE);
        applyStimulus(0, 0, 0, 0, 0, 32'hFF, 1, 0, 0);
        checkOutput("w3_busy2_htrans", htrans, T_BUSY);
        checkOutput("w3_busy2_hwdata", hwdata, 32'hB1);
        applyStimulus(0, 0, 0, 0, 1, 32'hB2, 1, 0, 0);
        checkOutput("w3_resume_htrans", htrans, T_SEQ);
        checkOutput("w3_resume_haddr", haddr, 32'h48);
        checkOutput("w3_resume_wr_ready", wrReady, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'hB3, 1, 0, 0);
        checkOutput("w3_c6_haddr", haddr, 32'h4C);
        checkOutput("w3_c6_hwdata", hwdata, 32'hB2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("w3_last_done", done, 1);
        checkOutput("w3_last_hwdata", hwdata, 32'hB3);
        checkOutput("w3_wr_count", wrCount, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("[TB] read across 1KB line at 0x3F8");
        applyStimulus(1, 0, 32'h3F8, 4'd3, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r4_b0_htrans", htrans, T_NSEQ);
        checkOutput("r4_b0_haddr", haddr, 32'h3F8);
        checkOutput("r4_b0_hburst", hburst, hb(3'b001));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h11);
        checkOutput("r4_b1_htrans", htrans, T_SEQ);
        checkOutput("r4_b1_haddr", haddr, 32'h3FC);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h12);
        checkOutput("r4_b2_htrans", htrans, T_NSEQ);
        checkOutput("r4_b2_haddr", haddr, 32'h400);
        checkOutput("r4_b2_hburst", hburst, hb(3'b001));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h13);
        checkOutput("r4_b3_htrans", htrans, T_SEQ);
        checkOutput("r4_b3_haddr", haddr, 32'h404);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h14);
        checkOutput("r4_last_done", done, 1);
        checkOutput("r4_last_rd_data", rdData, 32'h14);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("[TB] read with ERROR on beat 2");
        rdCount = 0;
        applyStimulus(1, 0, 32'h500, 4'd7, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r5_c1_haddr", haddr, 32'h500);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hE0);
        checkOutput("r5_b0_rd_data", rdData, 32'hE0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hE1);
        checkOutput("r5_b1_rd_data", rdData, 32'hE1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hE2);
        checkOutput("r5_err1_rd_valid", rdValid, 0);
        checkOutput("r5_err1_done", done, 0);
        checkOutput("r5_err1_haddr", haddr, 32'h50C);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hE2);
        checkOutput("r5_err2_htrans", htrans, T_IDLE);
        checkOutput("r5_err2_hsel", hsel, 0);
        checkOutput("r5_err2_done", done, 1);
        checkOutput("r5_err2_err", err, 1);
        checkOutput("r5_err2_rd_valid", rdValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hE3);
        checkOutput("r5_after_cmd_ready", cmdReady, 1);
        checkOutput("r5_after_done", done, 0);
        checkOutput("r5_after_err", err, 0);
        checkOutput("r5_after_htrans", htrans, T_IDLE);
        checkOutput("r5_rd_count", rdCount, 2);

        $display("[TB] reset during write beat 2");
        applyStimulus(1, 1, 32'h80, 4'd3, 1, 32'hC0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hC0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hC1, 1, 0, 0);
        @(posedge clk);
        #1;
        wrData = 32'hC2;
        rstN = 1'b0;
        #1;
        checkOutput("r6_rst_htrans", htrans, T_IDLE);
        checkOutput("r6_rst_haddr", haddr, 0);
        checkOutput("r6_rst_hwdata", hwdata, 0);
        checkOutput("r6_rst_hwrite", hwrite, 0);
        checkOutput("r6_rst_hburst", hburst, 3'b000);
        checkOutput("r6_rst_cmd_ready", cmdReady, 1);
        checkOutput("r6_rst_wr_ready", wrReady, 0);
        checkOutput("r6_rst_done", done, 0);
        checkOutput("r6_rst_hsel", hsel, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r6_post_done", done, 0);
        checkOutput("r6_post_htrans", htrans, T_IDLE);
        applyStimulus(1, 0, 32'h600, 4'd0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r6_next_htrans", htrans, T_NSEQ);
        checkOutput("r6_next_haddr", haddr, 32'h600);
        checkOutput("r6_next_hburst", hburst, 3'b000);
        checkOutput("r6_next_hwrite", hwrite, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hF0);
        checkOutput("r6_next_rd_valid", rdValid, 1);
        checkOutput("r6_next_rd_data", rdData, 32'hF0);
        checkOutput("r6_next_done", done, 1);
        checkOutput("r6_next_err", err, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
